// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the PC and the IF/ID decode stage.
//
// Takes the current PC, issues one instruction-memory request at a time, queues
// returned {pc, instr} pairs in a DEPTH-entry circular buffer and presents the head
// to decode under a valid/ready handshake. Drives the PC write enable so the PC only
// advances on an accepted fetch or loads a redirect target on flush.
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   When defined, an accepted ack into an empty queue is forwarded to decode in the
//   same cycle; if decode takes it, the entry is never written.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   pc_i           current PC
//   pcwrite_o      PC write enable (combinational)
//   imem_req_o     instruction-memory request (registered)
//   imem_addr_o    request address (registered, held while imem_req_o=1)
//   imem_ack_i     one-cycle memory response strobe
//   imem_data_i    instruction word, valid with imem_ack_i
//   flush_i        redirect: discard queue and any in-flight fetch
//   instr_valid_o  head entry valid
//   instr_o        head instruction (0 when empty)
//   instr_pc_o     PC of head instruction (0 when empty)
//   id_ready_i     decode accepts head this cycle
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pcwrite_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        flush_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        id_ready_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic            ack_ok;
  logic            not_empty;
  logic            push;
  logic            pop;

  assign not_empty = (count_q != '0);
  // Only a response to a live (non-dropped) request, not cancelled this cycle, counts.
  assign ack_ok    = (state_q == StWait) & imem_ack_i & ~flush_i;
  assign pop       = not_empty & id_ready_i & ~flush_i;
  assign pcwrite_o = ack_ok | flush_i;

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;

`ifdef FETCHQ_BYPASS_EN
  logic bypass;
  assign bypass = ack_ok & ~not_empty;
  // A bypassed word taken by decode in the ack cycle never enters the queue.
  assign push   = ack_ok & ~(bypass & id_ready_i);
`else
  assign push   = ack_ok;
`endif

  // Head presentation
  always_comb begin
    instr_valid_o = not_empty;
    instr_o       = '0;
    instr_pc_o    = '0;
    if (not_empty) begin
      instr_o    = instr_mem_q[rd_ptr_q];
      instr_pc_o = pc_mem_q[rd_ptr_q];
    end
`ifdef FETCHQ_BYPASS_EN
    else if (bypass) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_data_i;
      instr_pc_o    = addr_q;
    end
`endif
  end

  // Queue pointers and occupancy
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM. Issue only with free space: count cannot grow while a fetch is
  // outstanding, so the eventual push always has room.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (!flush_i && (count_q < DepthCnt)) begin
          req_d   = 1'b1;
          addr_d  = pc_i;
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (flush_i) begin
          // Request stays up: the memory handshake must complete before reissue.
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= addr_q;
      instr_mem_q[wr_ptr_q] <= imem_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
`ifdef FETCHQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pcwrite_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        flush_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        id_ready_i = 1'b0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .pcwrite_o    (pcwrite_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .flush_i      (flush_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .id_ready_i   (id_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  int total = 0;
  int bad   = 0;

  // Reference model: decode-visible queue plus the outstanding-fetch status.
  entry_t      mq[$];
  entry_t      consumed[$];
  bit          m_req  = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] tb_pc  = '0;
  int          lat_cnt = 0;
  int          lat_max = 0;
  int          pcw_seen = 0;
  int          cyc = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_req   = 1'b0;
    m_drop  = 1'b0;
    m_addr  = '0;
    lat_cnt = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  // ackm: 0 = memory with random latency, 1 = never ack, 2 = ack immediately.
  task automatic step(input bit fl, input logic [31:0] tgt, input int ackm, input bit rdy);
    bit          ack, acc, byp, ev, epw;
    logic [31:0] data, ei, ep;
    int          sz;
    @(negedge clk_i);
    cyc++;
    ack = 1'b0;
    if (m_req) begin
      if (ackm == 2) ack = 1'b1;
      else if (ackm == 0) begin
        if (lat_cnt == 0) ack = 1'b1;
        else lat_cnt--;
      end
    end
    data        = ack ? instr_of(m_addr) : $urandom;
    pc_i        = tb_pc;
    flush_i     = fl;
    imem_ack_i  = ack;
    imem_data_i = data;
    id_ready_i  = rdy;
    #1;
    sz  = mq.size();
    acc = m_req && !m_drop && ack && !fl;
    byp = Byp && acc && (sz == 0);
    ev  = (sz != 0) || byp;
    epw = acc || fl;
    if (sz != 0) begin
      ep = mq[0].pc;
      ei = mq[0].instr;
    end else if (byp) begin
      ep = m_addr;
      ei = data;
    end else begin
      ep = '0;
      ei = '0;
    end
    total += 6;
    if (imem_req_o !== m_req) begin
      bad++;
      $display("FAIL req cyc%0d: got %b exp %b", cyc, imem_req_o, m_req);
    end
    if (imem_addr_o !== m_addr) begin
      bad++;
      $display("FAIL addr cyc%0d: got %h exp %h", cyc, imem_addr_o, m_addr);
    end
    if (pcwrite_o !== epw) begin
      bad++;
      $display("FAIL pcwrite cyc%0d: got %b exp %b", cyc, pcwrite_o, epw);
    end
    if (instr_valid_o !== ev) begin
      bad++;
      $display("FAIL valid cyc%0d: got %b exp %b", cyc, instr_valid_o, ev);
    end
    if (instr_pc_o !== ep) begin
      bad++;
      $display("FAIL instr_pc cyc%0d: got %h exp %h", cyc, instr_pc_o, ep);
    end
    if (instr_o !== ei) begin
      bad++;
      $display("FAIL instr cyc%0d: got %h exp %h", cyc, instr_o, ei);
    end
    if (pcwrite_o === 1'b1) pcw_seen++;
    if (ev && rdy && !fl) consumed.push_back('{pc: ep, instr: ei});
    // Queue update
    if (fl) mq.delete();
    else begin
      if (sz != 0 && rdy) void'(mq.pop_front());
      if (acc && !(byp && rdy)) mq.push_back('{pc: m_addr, instr: data});
    end
    // Fetch engine update
    if (!m_req) begin
      if (!fl && sz < DEPTH) begin
        m_req   = 1'b1;
        m_addr  = tb_pc;
        m_drop  = 1'b0;
        lat_cnt = $urandom_range(0, lat_max);
      end
    end else if (ack) begin
      m_req  = 1'b0;
      m_drop = 1'b0;
    end else if (fl) begin
      m_drop = 1'b1;
    end
    if (epw) tb_pc = fl ? tgt : tb_pc + 32'd4;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i      = 1'b0;
    flush_i    = 1'b0;
    imem_ack_i = 1'b0;
    id_ready_i = 1'b0;
    #1;
    total += 4;
    if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL rst_req: got %b/%h exp 0/0", imem_req_o, imem_addr_o);
    end
    if (instr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid: got %b exp 0", instr_valid_o);
    end
    if (instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
      bad++;
      $display("FAIL rst_head: got %h/%h exp 0/0", instr_o, instr_pc_o);
    end
    if (pcwrite_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_pcwrite: got %b exp 0", pcwrite_o);
    end
    model_clear();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rel_pc;
    do_reset();
    tb_pc = 32'h100;
    step(0, '0, 1, 0);  // issue 0x100
    step(0, '0, 2, 0);  // ack, push
    step(0, '0, 1, 0);  // issue 0x104
    step(0, '0, 1, 0);  // waiting
    total += 2;
    if (imem_req_o !== 1'b1 || instr_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL pre_async: got req %b valid %b exp 1 1", imem_req_o, instr_valid_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || pcwrite_o !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: got req %b valid %b pcw %b exp 0 0 0",
               imem_req_o, instr_valid_o, pcwrite_o);
    end
    model_clear();
    @(posedge clk_i);
    #1;
    rst_i  = 1'b1;
    rel_pc = tb_pc;
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    total++;
    if (imem_addr_o !== rel_pc || imem_req_o !== 1'b1) begin
      bad++;
      $display("FAIL reissue: got %b/%h exp 1/%h", imem_req_o, imem_addr_o, rel_pc);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    tb_pc   = 32'h0;
    lat_max = 0;
    consumed.delete();
    pcw_seen = 0;
    for (int i = 0; i < 10; i++) step(0, '0, 0, 1);
    total++;
    if (consumed.size() < 3) begin
      bad++;
      $display("FAIL seq_count: got %0d exp >=3", consumed.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (consumed[i].pc !== 32'(4 * i) || consumed[i].instr !== instr_of(32'(4 * i))) begin
          bad++;
          $display("FAIL seq_order%0d: got %h/%h exp %h/%h", i, consumed[i].pc,
                   consumed[i].instr, 32'(4 * i), instr_of(32'(4 * i)));
        end
      end
    end
    total++;
    if (pcw_seen != 5) begin
      bad++;
      $display("FAIL seq_pcwrite: got %0d pulses exp 5", pcw_seen);
    end
  endtask

  task automatic test_full();
    do_reset();
    tb_pc = 32'h200;
    for (int i = 0; i < 12; i++) step(0, '0, 2, 0);
    total += 2;
    if (imem_req_o !== 1'b0 || pcwrite_o !== 1'b0) begin
      bad++;
      $display("FAIL full_stall: got req %b pcw %b exp 0 0", imem_req_o, pcwrite_o);
    end
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h200) begin
      bad++;
      $display("FAIL full_head: got %b/%h exp 1/200", instr_valid_o, instr_pc_o);
    end
    step(0, '0, 2, 1);
    pcw_seen = 0;
    for (int i = 0; i < 6; i++) step(0, '0, 2, 0);
    total++;
    if (pcw_seen != 1) begin
      bad++;
      $display("FAIL full_refill: got %0d fetches exp 1", pcw_seen);
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    tb_pc = 32'h10;
    step(0, '0, 1, 1);
    step(1, 32'h40, 1, 1);
    total++;
    if (pcwrite_o !== 1'b1 || imem_addr_o !== 32'h10) begin
      bad++;
      $display("FAIL fw_flush: got pcw %b addr %h exp 1 10", pcwrite_o, imem_addr_o);
    end
    step(0, '0, 1, 1);
    total++;
    if (imem_req_o !== 1'b1) begin
      bad++;
      $display("FAIL fw_drop_hold: got req %b exp 1", imem_req_o);
    end
    step(0, '0, 2, 1);
    total++;
    if (instr_valid_o !== 1'b0 || pcwrite_o !== 1'b0) begin
      bad++;
      $display("FAIL fw_discard: got valid %b pcw %b exp 0 0", instr_valid_o, pcwrite_o);
    end
    step(0, '0, 1, 1);
    step(0, '0, 2, 0);
    total++;
    if (imem_addr_o !== 32'h40) begin
      bad++;
      $display("FAIL fw_redirect: got %h exp 40", imem_addr_o);
    end
    step(0, '0, 1, 0);
    total++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h40) begin
      bad++;
      $display("FAIL fw_head: got %b/%h exp 1/40", instr_valid_o, instr_pc_o);
    end
  endtask

  task automatic test_flush_ack();
    do_reset();
    tb_pc = 32'h10;
    step(0, '0, 1, 1);
    step(1, 32'h40, 2, 1);
    total++;
    if (pcwrite_o !== 1'b1 || instr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL fa_cycle: got pcw %b valid %b exp 1 0", pcwrite_o, instr_valid_o);
    end
    step(0, '0, 1, 1);
    total++;
    if (instr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL fa_nodata: got valid %b exp 0", instr_valid_o);
    end
    step(0, '0, 1, 1);
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
      bad++;
      $display("FAIL fa_redirect: got %b/%h exp 1/40", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    tb_pc = 32'h20;
    step(0, '0, 1, 1);
    step(0, '0, 2, 1);
    total++;
    if (instr_valid_o !== Byp || (Byp && instr_pc_o !== 32'h20)) begin
      bad++;
      $display("FAIL byp_ack_cycle: got %b/%h exp %b/20", instr_valid_o, instr_pc_o, Byp);
    end
    step(0, '0, 1, 0);
    total++;
    if (instr_valid_o !== !Byp || instr_pc_o !== (Byp ? 32'h0 : 32'h20)) begin
      bad++;
      $display("FAIL byp_next: got %b/%h exp %b", instr_valid_o, instr_pc_o, !Byp);
    end
  endtask

  task automatic test_random();
    bit          fl;
    logic [31:0] tgt;
    do_reset();
    tb_pc   = 32'h1000;
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      fl  = ($urandom_range(0, 99) < 5);
      tgt = {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
      step(fl, tgt, 0, $urandom_range(0, 99) < 70);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_flush_wait();
    test_flush_ack();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
